// File: rtl/timer_sequencer.sv
// Microwave-style countdown sequencer: BCD M:SS keypad entry, tick-driven countdown, run/pause/done control.
// Optional beeper on completion is built only when TIMER_SEQUENCER_BEEP_EN is defined.
module timer_sequencer #(
  parameter int BEEP_CYCLES = 300
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_closed,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       done,
  output logic       div_en,
  output logic       beep
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t      state, state_n;
  logic [11:0] digits, digits_n, digits_dec;
  logic        tick_p0, tick_p1, tick_p2;
  logic        vld_p0, vld_p1, vld_p2;
  logic        tick_edge;

  // One BCD second off M:SS; a tens digit above 5 simply counts down like any other.
  function automatic logic [11:0] bcd_dec(input logic [11:0] t);
    logic [3:0] m, st, so;
    m  = t[11:8];
    st = t[7:4];
    so = t[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 4'd0) begin
      st = st - 4'd1;
      so = 4'd9;
    end else if (m != 4'd0) begin
      m  = m - 4'd1;
      st = 4'd5;
      so = 4'd9;
    end
    return {m, st, so};
  endfunction

  // Stage p0/p1: synchronizer; p2: edge-detect history. vld_p2 marks p2 as a real sample,
  // so a tick already high at reset release is never mistaken for a rising edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_p0 <= 1'b0;
      tick_p1 <= 1'b0;
      tick_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      tick_p0 <= tick;
      tick_p1 <= tick_p0;
      tick_p2 <= tick_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      vld_p2  <= vld_p1;
    end
  end

  assign tick_edge  = tick_p1 & ~tick_p2 & vld_p2;
  assign digits_dec = bcd_dec(digits);

  always_comb begin
    state_n  = state;
    digits_n = digits;
    unique case (state)
      IDLE: begin
        if (stop) begin
          digits_n = 12'h000;
        end else if (start && door_closed && (digits != 12'h000)) begin
          state_n = RUN;
        end else if (key_valid && (key_digit <= 4'd9)) begin
          digits_n = {digits[7:0], key_digit};
        end
      end
      RUN: begin
        if (stop || !door_closed) begin
          state_n = PAUSE;
        end else if (tick_edge) begin
          digits_n = digits_dec;
          if (digits_dec == 12'h000) state_n = DONE;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_n  = IDLE;
          digits_n = 12'h000;
        end else if (start && door_closed) begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (start || stop || key_valid) begin
          state_n  = IDLE;
          digits_n = 12'h000;
        end
      end
      default: begin
        state_n  = IDLE;
        digits_n = 12'h000;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      digits <= 12'h000;
      div_en <= 1'b0;
    end else begin
      state  <= state_n;
      digits <= digits_n;
      div_en <= (state_n == RUN);
    end
  end

  assign min_ones = digits[11:8];
  assign sec_tens = digits[7:4];
  assign sec_ones = digits[3:0];
  assign running  = (state == RUN);
  assign done     = (state == DONE);

`ifdef TIMER_SEQUENCER_BEEP_EN
  localparam int BW = $clog2(BEEP_CYCLES + 1);

  logic [BW-1:0] beep_cnt;
  logic          beep_q;

  // Beep rises with DONE and holds for BEEP_CYCLES clocks, cut short if DONE is left.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      beep_q   <= 1'b0;
      beep_cnt <= '0;
    end else if ((state_n == DONE) && (state != DONE)) begin
      beep_q   <= 1'b1;
      beep_cnt <= BW'(BEEP_CYCLES - 1);
    end else if (state_n != DONE) begin
      beep_q <= 1'b0;
    end else if (beep_cnt != '0) begin
      beep_cnt <= beep_cnt - 1'b1;
    end else begin
      beep_q <= 1'b0;
    end
  end

  assign beep = beep_q;
`else
  // Constant 0; referencing the parameter keeps it meaningful in this build.
  assign beep = (BEEP_CYCLES < 0);
`endif

endmodule
